fp_sig_mul_seq: RTL



---
 rtl/fp_sig_mul_seq_if.sv | 32 +++
 rtl/fp_sig_mul_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fp_sig_mul_seq_if.sv
// Operand/result handshake bundle for the iterative significand multiplier.
// slave = the multiplier itself, master = the upstream/downstream pair driving it.
interface fp_sig_mul_seq_if #(
   parameter int INTn = 32,
   parameter int NEXP = 8,
   parameter int NSIG = 23
);
   logic                   in_valid;
   logic                   in_ready;
   logic                   aNeg;
   logic signed [NEXP+1:0] aExp;
   logic        [NSIG:0]   aSig;
   logic                   bNeg;
   logic signed [NEXP+1:0] bExp;
   logic        [NSIG:0]   bSig;
   logic                   out_valid;
   logic                   out_ready;
   logic                   negOut;
   logic signed [NEXP+1:0] expOut;
   logic        [INTn-1:0] sigOut;
   logic                   zeroOut;

   modport slave (
      input  in_valid, aNeg, aExp, aSig, bNeg, bExp, bSig, out_ready,
      output in_ready, out_valid, negOut, expOut, sigOut, zeroOut
   );

   modport master (
      output in_valid, aNeg, aExp, aSig, bNeg, bExp, bSig, out_ready,
      input  in_ready, out_valid, negOut, expOut, sigOut, zeroOut
   );
endinterface

// File: rtl/fp_sig_mul_seq.sv
// Shift-add significand multiplier feeding the rounder (negIn/expIn/sigIn form).
// Define FP_SIG_MUL_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module fp_sig_mul_seq #(
   parameter int INTn = 32,
   parameter int NEXP = 8,
   parameter int NSIG = 23
) (
   input  logic               clk,
   input  logic               rst,
   fp_sig_mul_seq_if.slave    bus
);

`ifdef FP_SIG_MUL_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int ITER = (NSIG + STEP) / STEP;   // ceil((NSIG+1)/STEP)
   localparam int MW   = STEP * ITER;            // multiplier width padded to whole steps
   localparam int PW   = NSIG + 1 + MW;          // running product register width
   localparam int W    = 2 * NSIG + 2;           // exact product width
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} stateT;
   stateT state, stateNext;

   logic        [NSIG:0]    aReg;
   logic        [MW-1:0]    bReg;
   logic        [PW-1:0]    prod;
   logic        [CW-1:0]    cnt;
   logic signed [NEXP+1:0]  expSum;
   logic                    negReg, zeroReg;

   logic                    outValidQ, negQ, zeroQ;
   logic signed [NEXP+1:0]  expQ;
   logic        [INTn-1:0]  sigQ;

   logic accept, lastIter, handoff;
   assign accept   = bus.in_valid && (state == IDLE);
   assign lastIter = (cnt == CW'(ITER - 1));
   assign handoff  = outValidQ && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: if (accept)   stateNext = MUL;
         MUL:  if (lastIter) stateNext = NORM;
         NORM:               stateNext = DONE;
         DONE: if (handoff)  stateNext = IDLE;
      endcase
   end

   // Partial product selects 0..(2^STEP-1) x aSig from the low multiplier bits.
   logic [NSIG+STEP:0] partial, sum;
   logic [PW-1:0]      prodNext;
   always_comb begin
      // NOTE: blocking '=' is correct in combinational blocks; every always_ff here uses '<=' only.
      partial = '0;
      for (int j = 0; j < STEP; j++)
         if (bReg[j]) partial = partial + ({{STEP{1'b0}}, aReg} << j);
      sum      = {{STEP{1'b0}}, prod[PW-1:MW]} + partial;
      prodNext = {sum, prod[MW-1:STEP]};
   end

   // NOTE: datapath registers carry no reset; they are always loaded on accept before being used.
   always_ff @(posedge clk) begin
      if (accept) begin
         aReg    <= bus.aSig;
         bReg    <= MW'(bus.bSig);
         prod    <= '0;
         cnt     <= '0;
         expSum  <= bus.aExp + bus.bExp;
         negReg  <= bus.aNeg ^ bus.bNeg;
         zeroReg <= (bus.aSig == '0) || (bus.bSig == '0);
      end else if (state == MUL) begin
         prod <= prodNext;
         bReg <= bReg >> STEP;
         cnt  <= cnt + CW'(1);
      end
   end

   // Normalize so the product MSB lands in the top bit, then fit to INTn with sticky in bit 0.
   logic [W-1:0]    pFull, nrm;
   logic [INTn-1:0] sigNorm;
   assign pFull = prod[W-1:0];
   assign nrm   = pFull[W-1] ? pFull : {pFull[W-2:0], 1'b0};

   generate
      if (INTn < W) begin : gTrunc
         assign sigNorm = {nrm[W-1 -: INTn-1], nrm[W-INTn] | (|nrm[W-INTn-1:0])};
      end else if (INTn == W) begin : gExact
         assign sigNorm = nrm;
      end else begin : gPad
         assign sigNorm = {nrm, {(INTn-W){1'b0}}};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         outValidQ <= 1'b0;
         negQ      <= 1'b0;
         expQ      <= '0;
         sigQ      <= '0;
         zeroQ     <= 1'b0;
      end else if (state == NORM) begin
         outValidQ <= 1'b1;
         negQ      <= negReg;
         zeroQ     <= zeroReg;
         expQ      <= zeroReg ? '0 : (pFull[W-1] ? expSum + (NEXP+2)'(1) : expSum);
         sigQ      <= zeroReg ? '0 : sigNorm;
      end else if (handoff) begin
         outValidQ <= 1'b0;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = outValidQ;
   assign bus.negOut    = negQ;
   assign bus.expOut    = expQ;
   assign bus.sigOut    = sigQ;
   assign bus.zeroOut   = zeroQ;

endmodule
